ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 148 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Control/address half of a 5-stage MIPS-style pipeline: ID/EX, EX/MEM and MEM/WB
// registers plus the operand forwarding selects for the execute stage.
module ctrl_pipe #(
   parameter int FWD_EN = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       memtoregD,
   input  logic       memwriteD,
   input  logic       alusrcD,
   input  logic       regdstD,
   input  logic       regwriteD,
   input  logic       branchD,
   input  logic       jumpD,
   input  logic [2:0] alucontrolD,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic [4:0] rdD,
   input  logic       stallE,
   input  logic       flushE,
   output logic       memtoregE,
   output logic       memwriteE,
   output logic       alusrcE,
   output logic       regwriteE,
   output logic       branchE,
   output logic       jumpE,
   output logic [2:0] alucontrolE,
   output logic [4:0] rsE,
   output logic [4:0] rtE,
   output logic [4:0] writeregE,
   output logic       memtoregM,
   output logic       memwriteM,
   output logic       regwriteM,
   output logic [4:0] writeregM,
   output logic       memtoregW,
   output logic       regwriteW,
   output logic [4:0] writeregW,
   output logic [1:0] forwardAE,
   output logic [1:0] forwardBE
);

   typedef struct packed {
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic       regdst;
      logic       regwrite;
      logic       branch;
      logic       jump;
      logic [2:0] alucontrol;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } idex_t;

   idex_t idex_reg;
   idex_t idex_next;

   assign idex_next = '{memtoreg:   memtoregD,
                        memwrite:   memwriteD,
                        alusrc:     alusrcD,
                        regdst:     regdstD,
                        regwrite:   regwriteD,
                        branch:     branchD,
                        jump:       jumpD,
                        alucontrol: alucontrolD,
                        rs:         rsD,
                        rt:         rtD,
                        rd:         rdD};

   // Flush wins over stall; a held stage keeps its instruction in place.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         idex_reg <= '0;
      else if (flushE)
         idex_reg <= '0;
      else if (!stallE)
         idex_reg <= idex_next;
   end

   assign memtoregE   = idex_reg.memtoreg;
   assign memwriteE   = idex_reg.memwrite;
   assign alusrcE     = idex_reg.alusrc;
   assign regwriteE   = idex_reg.regwrite;
   assign branchE     = idex_reg.branch;
   assign jumpE       = idex_reg.jump;
   assign alucontrolE = idex_reg.alucontrol;
   assign rsE         = idex_reg.rs;
   assign rtE         = idex_reg.rt;
   assign writeregE   = idex_reg.regdst ? idex_reg.rd : idex_reg.rt;

   // While E is held, M must take a bubble so the held instruction is not issued twice.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         memtoregM <= 1'b0;
         memwriteM <= 1'b0;
         regwriteM <= 1'b0;
         writeregM <= 5'd0;
      end else if (stallE && !flushE) begin
         memtoregM <= 1'b0;
         memwriteM <= 1'b0;
         regwriteM <= 1'b0;
         writeregM <= 5'd0;
      end else begin
         memtoregM <= memtoregE;
         memwriteM <= memwriteE;
         regwriteM <= regwriteE;
         writeregM <= writeregE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         memtoregW <= 1'b0;
         regwriteW <= 1'b0;
         writeregW <= 5'd0;
      end else begin
         memtoregW <= memtoregM;
         regwriteW <= regwriteM;
         writeregW <= writeregM;
      end
   end

   // Operand 0 is rs (A), operand 1 is rt (B); the M-stage producer is the newer one.
   logic [1:0][4:0] fwd_src;
   logic [1:0][1:0] fwd_sel;

   assign fwd_src = {rtE, rsE};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         if (FWD_EN != 0) begin : g_on
            logic hit_m;
            logic hit_w;
            assign hit_m = regwriteM && (writeregM != 5'd0) && (writeregM == fwd_src[gi]);
            assign hit_w = regwriteW && (writeregW != 5'd0) && (writeregW == fwd_src[gi]);
            assign fwd_sel[gi] = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
         end else begin : g_off
            assign fwd_sel[gi] = 2'b00;
         end
      end
   endgenerate

   assign forwardAE = fwd_sel[0];
   assign forwardBE = fwd_sel[1];

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: stage latency, flush/stall, forwarding priority and async reset.
module tb_ctrl_pipe;

   logic       clk;
   logic       reset;
   logic       memtoregD, memwriteD, alusrcD, regdstD, regwriteD, branchD, jumpD;
   logic [2:0] alucontrolD;
   logic [4:0] rsD, rtD, rdD;
   logic       stallE, flushE;

   logic       memtoregE, memwriteE, alusrcE, regwriteE, branchE, jumpE;
   logic [2:0] alucontrolE;
   logic [4:0] rsE, rtE, writeregE;
   logic       memtoregM, memwriteM, regwriteM;
   logic [4:0] writeregM;
   logic       memtoregW, regwriteW;
   logic [4:0] writeregW;
   logic [1:0] forwardAE, forwardBE;

   logic       memtoregE0, memwriteE0, alusrcE0, regwriteE0, branchE0, jumpE0;
   logic [2:0] alucontrolE0;
   logic [4:0] rsE0, rtE0, writeregE0;
   logic       memtoregM0, memwriteM0, regwriteM0;
   logic [4:0] writeregM0;
   logic       memtoregW0, regwriteW0;
   logic [4:0] writeregW0;
   logic [1:0] forwardAE0, forwardBE0;

   int n_checks = 0;
   int n_fail   = 0;

   ctrl_pipe #(.FWD_EN(1)) dut (
      .clk(clk), .reset(reset),
      .memtoregD(memtoregD), .memwriteD(memwriteD), .alusrcD(alusrcD), .regdstD(regdstD),
      .regwriteD(regwriteD), .branchD(branchD), .jumpD(jumpD), .alucontrolD(alucontrolD),
      .rsD(rsD), .rtD(rtD), .rdD(rdD), .stallE(stallE), .flushE(flushE),
      .memtoregE(memtoregE), .memwriteE(memwriteE), .alusrcE(alusrcE), .regwriteE(regwriteE),
      .branchE(branchE), .jumpE(jumpE), .alucontrolE(alucontrolE), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .memtoregM(memtoregM), .memwriteM(memwriteM),
      .regwriteM(regwriteM), .writeregM(writeregM), .memtoregW(memtoregW),
      .regwriteW(regwriteW), .writeregW(writeregW), .forwardAE(forwardAE), .forwardBE(forwardBE)
   );

   ctrl_pipe #(.FWD_EN(0)) dut_nofwd (
      .clk(clk), .reset(reset),
      .memtoregD(memtoregD), .memwriteD(memwriteD), .alusrcD(alusrcD), .regdstD(regdstD),
      .regwriteD(regwriteD), .branchD(branchD), .jumpD(jumpD), .alucontrolD(alucontrolD),
      .rsD(rsD), .rtD(rtD), .rdD(rdD), .stallE(stallE), .flushE(flushE),
      .memtoregE(memtoregE0), .memwriteE(memwriteE0), .alusrcE(alusrcE0), .regwriteE(regwriteE0),
      .branchE(branchE0), .jumpE(jumpE0), .alucontrolE(alucontrolE0), .rsE(rsE0), .rtE(rtE0),
      .writeregE(writeregE0), .memtoregM(memtoregM0), .memwriteM(memwriteM0),
      .regwriteM(regwriteM0), .writeregM(writeregM0), .memtoregW(memtoregW0),
      .regwriteW(regwriteW0), .writeregW(writeregW0), .forwardAE(forwardAE0), .forwardBE(forwardBE0)
   );

   logic [42:0] outs, outs0;
   logic [23:0] e_outs;
   logic [8:0]  m_outs;

   assign e_outs = {memtoregE, memwriteE, alusrcE, regwriteE, branchE, jumpE,
                    alucontrolE, rsE, rtE, writeregE};
   assign m_outs = {memtoregM, memwriteM, regwriteM, writeregM};
   assign outs   = {e_outs, m_outs, memtoregW, regwriteW, writeregW, forwardAE, forwardBE};
   assign outs0  = {memtoregE0, memwriteE0, alusrcE0, regwriteE0, branchE0, jumpE0,
                    alucontrolE0, rsE0, rtE0, writeregE0, memtoregM0, memwriteM0, regwriteM0,
                    writeregM0, memtoregW0, regwriteW0, writeregW0, forwardAE0, forwardBE0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic [2:0] alu, input logic mtr, input logic mw, input logic as,
                        input logic rdst, input logic rw, input logic br, input logic jp,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      alucontrolD = alu; memtoregD = mtr; memwriteD = mw; alusrcD = as; regdstD = rdst;
      regwriteD = rw; branchD = br; jumpD = jp; rsD = rs; rtD = rt; rdD = rd;
   endtask

   task automatic clear_d();
      set_d(3'b000, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic drain();
      clear_d();
      repeat (3) step();
   endtask

   initial begin
      stallE = 1'b0;
      flushE = 1'b0;
      reset  = 1'b1;
      set_d(3'b111, 1, 1, 1, 1, 1, 1, 1, 5'd9, 5'd9, 5'd9);
      step();
      step();
      $display("txn reset-hold");
      check_value("reset_outs", outs, 43'd0);
      check_value("reset_outs_nofwd", outs0, 43'd0);

      // R-type add leaving reset: only E sees it on the first edge
      set_d(3'b010, 0, 0, 0, 1, 1, 0, 0, 5'd0, 5'd6, 5'd5);
      reset = 1'b0;
      step();
      clear_d();
      $display("txn add rd=5");
      check_value("add_E_alu", alucontrolE, 3'b010);
      check_value("add_E_wreg", writeregE, 5'd5);
      check_value("add_E_rw", regwriteE, 1'b1);
      check_value("add_firstedge_M", m_outs, 9'd0);
      check_value("add_firstedge_Wrw", regwriteW, 1'b0);
      step();
      check_value("add_M_rw", regwriteM, 1'b1);
      check_value("add_M_wreg", writeregM, 5'd5);
      check_value("add_E_bubble", e_outs, 24'd0);
      step();
      check_value("add_W_rw", regwriteW, 1'b1);
      check_value("add_W_wreg", writeregW, 5'd5);
      check_value("add_M_bubble", m_outs, 9'd0);
      step();
      check_value("add_W_bubble", {regwriteW, writeregW}, 6'd0);

      // lw followed by a flushed instruction
      set_d(3'b010, 1, 0, 1, 0, 1, 0, 0, 5'd2, 5'd8, 5'd0);
      step();
      $display("txn lw rt=8 then flush");
      check_value("lw_E_wreg", writeregE, 5'd8);
      check_value("lw_E_ctl", {memtoregE, alusrcE, regwriteE}, 3'b111);
      set_d(3'b110, 0, 1, 0, 1, 1, 1, 1, 5'd1, 5'd2, 5'd9);
      flushE = 1'b1;
      step();
      flushE = 1'b0;
      clear_d();
      check_value("flush_E_zero", e_outs, 24'd0);
      check_value("lw_M", m_outs, {1'b1, 1'b0, 1'b1, 5'd8});
      step();
      check_value("lw_W", {memtoregW, regwriteW, writeregW}, {2'b11, 5'd8});
      check_value("flush_M_zero", m_outs, 9'd0);
      step();
      check_value("flush_W_zero", {memtoregW, regwriteW, writeregW}, 7'd0);

      // store/branch/jump bits pass through
      set_d(3'b001, 0, 1, 1, 0, 0, 1, 1, 5'd4, 5'd7, 5'd0);
      step();
      clear_d();
      $display("txn sw/br/j bits");
      check_value("sbj_E_bits", {memwriteE, branchE, jumpE, alusrcE}, 4'b1111);
      check_value("sbj_E_rsrt", {rsE, rtE}, {5'd4, 5'd7});
      step();
      check_value("sbj_M_mw", memwriteM, 1'b1);
      drain();

      // stall for two cycles with add rd=5 in E
      set_d(3'b010, 0, 0, 0, 1, 1, 0, 0, 5'd1, 5'd6, 5'd5);
      step();
      $display("txn stall x2 add rd=5");
      set_d(3'b110, 0, 0, 0, 1, 1, 0, 0, 5'd2, 5'd3, 5'd7);
      stallE = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check_value("stall_E_hold", {alucontrolE, writeregE, regwriteE}, {3'b010, 5'd5, 1'b1});
         check_value("stall_M_bubble", {regwriteM, writeregM}, 6'd0);
      end
      stallE = 1'b0;
      clear_d();
      step();
      check_value("stall_M_once", {regwriteM, writeregM}, {1'b1, 5'd5});
      step();
      check_value("stall_M_after", {regwriteM, writeregM}, 6'd0);
      check_value("stall_W", {regwriteW, writeregW}, {1'b1, 5'd5});
      drain();

      // back-to-back writes to $3, consumer rs=rt=3
      $display("txn fwd $3 M/W");
      set_d(3'b010, 0, 0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd3);
      step();
      step();
      set_d(3'b010, 0, 0, 0, 1, 0, 0, 0, 5'd3, 5'd3, 5'd20);
      step();
      clear_d();
      check_value("fwd3_A_MW", forwardAE, 2'b10);
      check_value("fwd3_B_MW", forwardBE, 2'b10);
      check_value("fwd3_A_nofwd", forwardAE0, 2'b00);
      stallE = 1'b1;
      step();
      stallE = 1'b0;
      check_value("fwd3_A_W", forwardAE, 2'b01);
      check_value("fwd3_B_W", forwardBE, 2'b01);
      drain();
      check_value("fwd_idle", {forwardAE, forwardBE}, 4'd0);

      // distinct producers: rs hits M, rt hits W
      $display("txn fwd mixed rs=11 rt=10");
      set_d(3'b010, 0, 0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd10);
      step();
      set_d(3'b010, 0, 0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd11);
      step();
      set_d(3'b010, 0, 0, 0, 1, 0, 0, 0, 5'd11, 5'd10, 5'd0);
      step();
      check_value("mix_A", forwardAE, 2'b10);
      check_value("mix_B", forwardBE, 2'b01);
      drain();

      // writes to $0 never forward
      $display("txn fwd $0");
      set_d(3'b010, 0, 0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      step();
      set_d(3'b010, 0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd1);
      step();
      clear_d();
      check_value("zero_A_M", {regwriteM, forwardAE, forwardBE}, {1'b1, 4'b0000});
      stallE = 1'b1;
      step();
      stallE = 1'b0;
      check_value("zero_A_W", {regwriteW, forwardAE}, {1'b1, 2'b00});
      drain();

      // FWD_EN=0 never forwards a real hazard
      $display("txn fwd disabled rs=4");
      set_d(3'b010, 0, 0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd4);
      step();
      set_d(3'b010, 0, 0, 0, 1, 0, 0, 0, 5'd4, 5'd0, 5'd1);
      step();
      clear_d();
      check_value("nofwd_en1_A", forwardAE, 2'b10);
      check_value("nofwd_en0_A", {writeregM0, forwardAE0}, {5'd4, 2'b00});
      drain();

      // asynchronous reset with every stage occupied
      $display("txn async reset mid-flight");
      set_d(3'b010, 0, 0, 0, 1, 1, 0, 0, 5'd1, 5'd0, 5'd12);
      step();
      set_d(3'b010, 0, 0, 0, 1, 1, 0, 0, 5'd1, 5'd0, 5'd13);
      step();
      set_d(3'b010, 0, 0, 0, 1, 1, 0, 0, 5'd12, 5'd13, 5'd14);
      step();
      set_d(3'b010, 0, 0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd15);
      check_value("full_before_rst", {writeregE, writeregM, writeregW, forwardAE, forwardBE},
                  {5'd14, 5'd13, 5'd12, 2'b01, 2'b10});
      #3 reset = 1'b1;
      #1;
      check_value("async_rst_outs", outs, 43'd0);
      check_value("async_rst_outs_nofwd", outs0, 43'd0);
      step();
      check_value("rst_held_outs", outs, 43'd0);
      reset = 1'b0;
      step();
      check_value("post_rst_E", {regwriteE, writeregE}, {1'b1, 5'd15});
      check_value("post_rst_MW", {m_outs, regwriteW, writeregW}, 15'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
